// File: rtl/e1_rx_bd_mgr.sv
// E1 receive buffer-descriptor manager.
// Software submits empty multiframe buffer indices into an "empty" FIFO. The
// E1 receiver consumes the head index; each completed multiframe moves that
// index, tagged with its two sub-multiframe CRC flags, into a "done" FIFO for
// software to collect. Also keeps a saturating miss counter and a sticky
// done-FIFO overflow flag.
module e1_rx_bd_mgr #(
  parameter int MFW   = 7,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [MFW-1:0]         sub_mf,
  input  logic                   sub_valid,
  output logic                   sub_ready,
  output logic [MFW-1:0]         done_mf,
  output logic [1:0]             done_crc_e,
  output logic                   done_valid,
  input  logic                   done_ready,
  output logic [MFW-1:0]         bd_mf,
  output logic                   bd_valid,
  input  logic [1:0]             bd_crc_e,
  input  logic                   bd_done,
  input  logic                   bd_miss,
  input  logic                   rx_enable,
  input  logic                   flush,
  input  logic                   clr_stat,
  output logic [$clog2(DEPTH):0] free_cnt,
  output logic [$clog2(DEPTH):0] done_cnt,
  output logic [15:0]            miss_cnt,
  output logic                   ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = MFW + 2;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Storage (no reset) and state registers
  logic [MFW-1:0] r_free_mem [DEPTH];
  logic [DW-1:0]  r_done_mem [DEPTH];
  logic [AW-1:0]  r_free_wr, r_free_rd;
  logic [AW-1:0]  r_done_wr, r_done_rd;
  logic [CW-1:0]  r_free_cnt, r_done_cnt;
  logic [15:0]    r_miss_cnt;
  logic           r_ovf;

  logic w_free_full, w_free_empty, w_done_full, w_done_empty;
  logic w_sub_push, w_free_pop, w_done_pop, w_done_push, w_ovf_evt;

  assign w_free_full  = (r_free_cnt == FULL_CNT);
  assign w_free_empty = (r_free_cnt == '0);
  assign w_done_full  = (r_done_cnt == FULL_CNT);
  assign w_done_empty = (r_done_cnt == '0);

  // Flush suppresses every FIFO operation in its cycle.
  assign w_sub_push  = sub_valid & ~w_free_full & ~flush;
  assign w_free_pop  = bd_done & ~w_free_empty & ~flush;
  assign w_done_pop  = done_ready & ~w_done_empty & ~flush;
  // A full done FIFO still takes the entry when its head leaves this cycle.
  assign w_done_push = w_free_pop & (~w_done_full | w_done_pop);
  assign w_ovf_evt   = w_free_pop & w_done_full & ~w_done_pop;

  assign sub_ready  = ~w_free_full;
  assign bd_mf      = r_free_mem[r_free_rd];
  assign bd_valid   = ~w_free_empty & rx_enable;
  assign {done_mf, done_crc_e} = r_done_mem[r_done_rd];
  assign done_valid = ~w_done_empty;
  assign free_cnt   = r_free_cnt;
  assign done_cnt   = r_done_cnt;
  assign miss_cnt   = r_miss_cnt;
  assign ovf        = r_ovf;

  // Write FIFO payloads.
  // NOTE: payload arrays carry no reset; only pointers and counts define validity, which lets them map to RAM.
  always_ff @(posedge clk) begin
    if (w_sub_push)  r_free_mem[r_free_wr] <= sub_mf;
    if (w_done_push) r_done_mem[r_done_wr] <= {bd_mf, bd_crc_e};
  end

  // Empty FIFO pointers and occupancy.
  // NOTE: all clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_free_wr  <= '0;
      r_free_rd  <= '0;
      r_free_cnt <= '0;
    end else if (flush) begin
      r_free_wr  <= '0;
      r_free_rd  <= '0;
      r_free_cnt <= '0;
    end else begin
      if (w_sub_push) r_free_wr <= r_free_wr + AW'(1);
      if (w_free_pop) r_free_rd <= r_free_rd + AW'(1);
      if (w_sub_push && !w_free_pop)      r_free_cnt <= r_free_cnt + CW'(1);
      else if (!w_sub_push && w_free_pop) r_free_cnt <= r_free_cnt - CW'(1);
    end
  end

  // Done FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done_wr  <= '0;
      r_done_rd  <= '0;
      r_done_cnt <= '0;
    end else if (flush) begin
      r_done_wr  <= '0;
      r_done_rd  <= '0;
      r_done_cnt <= '0;
    end else begin
      if (w_done_push) r_done_wr <= r_done_wr + AW'(1);
      if (w_done_pop)  r_done_rd <= r_done_rd + AW'(1);
      if (w_done_push && !w_done_pop)      r_done_cnt <= r_done_cnt + CW'(1);
      else if (!w_done_push && w_done_pop) r_done_cnt <= r_done_cnt - CW'(1);
    end
  end

  // Statistics: saturating miss counter and sticky overflow; same-cycle events survive a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_miss_cnt <= '0;
      r_ovf      <= 1'b0;
    end else begin
      if (clr_stat)                              r_miss_cnt <= bd_miss ? 16'd1 : 16'd0;
      else if (bd_miss && r_miss_cnt != 16'hFFFF) r_miss_cnt <= r_miss_cnt + 16'd1;

      if (clr_stat)       r_ovf <= w_ovf_evt;
      else if (w_ovf_evt) r_ovf <= 1'b1;
    end
  end

endmodule

// File: doc/e1_rx_bd_mgr.md
E1_RX_BD_MGR -- requirements
Module: e1_rx_bd_mgr

Interface
REQ-001 SHALL have parameter MFW, default 7: multiframe buffer index width.
REQ-002 SHALL have parameter DEPTH, default 4: entries per descriptor FIFO; power of two, 2..16.
REQ-003 SHALL have port clk  in  1: sole clock; all logic rising-edge.
REQ-004 SHALL have port rst_n  in  1: asynchronous, active-low reset.
REQ-005 SHALL have port sub_mf  in  MFW: empty buffer index submitted by software.
REQ-006 SHALL have port sub_valid  in  1: submit request.
REQ-007 SHALL have port sub_ready  out  1: empty FIFO can accept.
REQ-008 SHALL have port done_mf  out  MFW: completed buffer index at done FIFO head.
REQ-009 SHALL have port done_crc_e  out  2: CRC error flags of the two sub-multiframes of that buffer.
REQ-010 SHALL have port done_valid  out  1: done FIFO not empty.
REQ-011 SHALL have port done_ready  in  1: pop done FIFO.
REQ-012 SHALL have port bd_mf  out  MFW: buffer index presented to E1 RX.
REQ-013 SHALL have port bd_valid  out  1: bd_mf usable.
REQ-014 SHALL have port bd_crc_e  in  2: CRC flags from E1 RX, sampled with bd_done.
REQ-015 SHALL have port bd_done  in  1: single-cycle pulse, current multiframe complete.
REQ-016 SHALL have port bd_miss  in  1: single-cycle pulse, multiframe start with no buffer.
REQ-017 SHALL have port rx_enable  in  1: gates bd_valid.
REQ-018 SHALL have port flush  in  1: single-cycle pulse, empties both FIFOs.
REQ-019 SHALL have port clr_stat  in  1: single-cycle pulse, clears statistics.
REQ-020 SHALL have port free_cnt  out  log2(DEPTH)+1: empty FIFO occupancy.
REQ-021 SHALL have port done_cnt  out  log2(DEPTH)+1: done FIFO occupancy.
REQ-022 SHALL have port miss_cnt  out  16: saturating miss counter.
REQ-023 SHALL have port ovf  out  1: sticky done FIFO overflow flag.

Function
REQ-024 SHALL push sub_mf into the empty FIFO on each clk where sub_valid and sub_ready are both 1; sub_ready = (free_cnt != DEPTH), with no same-cycle bypass from pop.
REQ-025 SHALL drive bd_mf from the empty FIFO head and bd_valid = (free_cnt != 0) & rx_enable, both combinational from registered state.
REQ-026 SHALL change the bd_mf head only on a bd_done pop or a flush, so it stays stable across a multiframe.
REQ-027 SHALL, on bd_done with free_cnt != 0, pop the empty FIFO and push {bd_mf, bd_crc_e} into the done FIFO in the same cycle.
REQ-028 SHALL ignore bd_done when free_cnt == 0, with no state change.
REQ-029 SHALL, when bd_done would push while done_cnt == DEPTH and done_ready is 0, still pop the empty FIFO, drop the entry and set ovf.
REQ-030 SHALL accept the push on a full done FIFO when done_ready pops in the same cycle; done_cnt is then unchanged.
REQ-031 SHALL pop the done FIFO when done_valid & done_ready; done_mf and done_crc_e reflect the head combinationally.
REQ-032 SHALL add 1 to miss_cnt on each bd_miss, saturating at 0xFFFF.
REQ-033 SHALL, on clr_stat, clear miss_cnt to 0 and ovf to 0; a simultaneous bd_miss yields miss_cnt = 1, and a simultaneous overflow yields ovf = 1.
REQ-034 SHALL, on flush, clear both FIFO pointers and counts; flush wins over any same-cycle push or pop, and statistics are unaffected.
REQ-035 SHALL keep bd_valid = 0 while rx_enable = 0 without altering FIFO contents.
REQ-036 SHALL make every state change visible on outputs the cycle after the causing edge.
REQ-037 SHALL hold FIFO storage in registers or inferred RAM; only pointers and counters are reset.

Reset
REQ-038 SHALL, while rst_n = 0 and asynchronously, force free_cnt = 0, done_cnt = 0, miss_cnt = 0, ovf = 0, sub_ready = 1, bd_valid = 0 and done_valid = 0.
REQ-039 SHALL resume operation on the first clk edge after rst_n deasserts, with no pending pulse state retained.

Verification
REQ-040 SHALL cover: submit 3,5; rx_enable = 1 -> bd_mf = 3, bd_valid = 1; bd_done with crc_e = 2'b10 -> bd_mf = 5, done_mf = 3, done_crc_e = 2'b10, done_cnt = 1.
REQ-041 SHALL cover: submit 4 entries (DEPTH 4) -> sub_ready = 0; a fifth sub_valid is not accepted; bd_done -> sub_ready = 1 next cycle.
REQ-042 SHALL cover: done FIFO full, bd_done with done_ready = 0 -> ovf = 1, done_cnt = 4, free_cnt decremented; repeat with done_ready = 1 -> ovf unchanged, new entry at tail.
REQ-043 SHALL cover: 65537 bd_miss pulses -> miss_cnt = 0xFFFF; clr_stat together with bd_miss -> miss_cnt = 1.
REQ-044 SHALL cover: flush during simultaneous sub_valid and bd_done -> free_cnt = 0, done_cnt = 0 next cycle, bd_valid = 0.
REQ-045 SHALL cover: rst_n asserted mid-traffic, asynchronously between edges -> all outputs reach the REQ-038 values before the next clk edge.
